// File: rtl/mem_defs.sv
// -----------------------------------------------------------------------------
// mem_defs
// Shared definitions for the main-memory controller slice: default geometry,
// latency, block-offset width and the controller FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_defs;

    localparam int DEF_ADDR_WIDTH      = 10;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_LATENCY         = 4;

    // Number of byte-offset bits inside one block of 32-bit words.
    function automatic int block_bits(input int words_per_block);
        return $clog2(4 * words_per_block);
    endfunction

    localparam int BLOCK_BITS = block_bits(DEF_WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_block_array.sv
// -----------------------------------------------------------------------------
// mem_block_array
// Block-organised storage: one block-wide synchronous write port and one
// block-wide combinational read port sharing a single block index. No reset,
// so contents survive controller resets.
//   clk      : clock
//   i_we     : write enable, whole block written on the rising edge
//   i_idx    : block index for both read and write
//   i_wdata  : block write data, word 0 in the low 32 bits
//   o_rdata  : block read data at i_idx
// -----------------------------------------------------------------------------
module mem_block_array #(
    parameter int IDX_W = 6,
    parameter int DW    = 128
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [DW-1:0]    i_wdata,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/main_memory_ctrl.sv
// -----------------------------------------------------------------------------
// main_memory_ctrl
// Fixed-latency block memory behind a cache. Accepts one block fill or
// write-back at a time, completes it LATENCY edges after accept and pulses
// resp_valid for one cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   req_valid    : request present
//   req_write    : 1 = write-back, 0 = fill
//   req_addr     : byte address of the block (offset bits ignored)
//   req_wdata    : write-back block, word 0 in [31:0]
//   req_ready    : controller idle, request will be accepted
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : fill data, held until the next fill completes
//
// state   | meaning
// --------+--------------------------------------------------------------------
// ST_IDLE | ready; accept on req_valid
// ST_WAIT | latency countdown; leaves when the counter reaches 0
// ST_RESP | final latency cycle; commit/read happens on the edge leaving it
//
// resp_valid is registered off ST_RESP, so the pulse lands in the first IDLE
// cycle and the next request can be accepted on the edge that ends the pulse.
// With LATENCY=1 the countdown is already 0 at accept, so IDLE goes straight
// to RESP.
// -----------------------------------------------------------------------------
module main_memory_ctrl
    import mem_defs::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int LATENCY         = DEF_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [32*WORDS_PER_BLOCK-1:0] req_wdata,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [32*WORDS_PER_BLOCK-1:0] resp_rdata
);

    localparam int         BB       = block_bits(WORDS_PER_BLOCK);
    localparam int         IDX_W    = ADDR_WIDTH - BB;
    localparam int         DW       = 32 * WORDS_PER_BLOCK;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [IDX_W-1:0]   r_idx;
    logic [DW-1:0]      r_wdata;
    logic               r_resp_valid;
    logic [DW-1:0]      r_rdata;

    logic               w_req_ready;
    logic               w_accept;
    logic               w_mem_we;
    logic               w_rd_load;
    logic [DW-1:0]      w_mem_rdata;
    logic               w_unused_addr;

    assign w_unused_addr = ^req_addr[BB-1:0];
    assign w_accept      = req_valid & w_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd1) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = (r_state == ST_IDLE);
        w_mem_we    = (r_state == ST_RESP) &  r_write;
        w_rd_load   = (r_state == ST_RESP) & ~r_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_idx   <= req_addr[ADDR_WIDTH-1:BB];
                r_wdata <= req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_resp_valid <= (r_state == ST_RESP);
            if (w_rd_load) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    mem_block_array #(
        .IDX_W (IDX_W),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_main_memory_ctrl.sv
module tb_main_memory_ctrl;

    logic         clk;
    logic         reset_n;

    logic         a_req_valid, a_req_write, a_req_ready, a_resp_valid;
    logic [9:0]   a_req_addr;
    logic [127:0] a_req_wdata, a_resp_rdata;

    logic         b_req_valid, b_req_write, b_req_ready, b_resp_valid;
    logic [9:0]   b_req_addr;
    logic [127:0] b_req_wdata, b_resp_rdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D0 = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] D8 = 128'h88888883_88888882_88888881_88888880;
    localparam logic [127:0] DX = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

    main_memory_ctrl #(.ADDR_WIDTH(10), .WORDS_PER_BLOCK(4), .LATENCY(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata)
    );

    main_memory_ctrl #(.ADDR_WIDTH(10), .WORDS_PER_BLOCK(4), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request into the LATENCY=4 instance, returns edges from accept
    // to the first resp_valid sample (-1 on timeout) and resp_rdata at that point.
    task automatic xfer(input logic w, input logic [9:0] addr, input logic [127:0] data,
                        output int lat, output logic [127:0] rd);
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = data;
        tick;
        a_req_valid = 1'b0; a_req_addr = ~addr; a_req_wdata = ~data;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (a_resp_valid) begin
                lat = n;
                break;
            end
        end
        rd = a_resp_rdata;
    endtask

    task automatic test_reset;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 128'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", a_resp_rdata); end
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_l1: got %b expected 1", b_req_ready); end
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid_l1: got %b expected 0", b_resp_valid); end
    endtask

    task automatic test_init;
        int lat; logic [127:0] rd;
        xfer(1'b1, 10'h000, D0, lat, rd);
        checks++; if (lat != 4) begin failures++; $display("FAIL init_wr0_latency: got %0d expected 4", lat); end
        xfer(1'b1, 10'h080, D8, lat, rd);
        checks++; if (lat != 4) begin failures++; $display("FAIL init_wr8_latency: got %0d expected 4", lat); end
        checks++; if (rd !== 128'h0) begin failures++; $display("FAIL write_keeps_rdata: got %h expected 0", rd); end
    endtask

    task automatic test_write_read;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 10'h040; a_req_wdata = D1;
        tick;                                          // edge k
        a_req_valid = 1'b0; a_req_wdata = ~D1; a_req_addr = 10'h3F0;
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL wr_ready_busy: got %b expected 0", a_req_ready); end
        for (int n = 1; n <= 3; n++) begin
            tick;
            checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL wr_early_resp k+%0d: got %b expected 0", n, a_resp_valid); end
        end
        tick;                                          // edge k+4
        checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL wr_resp_k4: got %b expected 1", a_resp_valid); end
        checks++; if (a_resp_rdata !== 128'h0) begin failures++; $display("FAIL wr_rdata_unchanged: got %h expected 0", a_resp_rdata); end
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 10'h04C;
        tick;                                          // edge k+5
        a_req_valid = 1'b0; a_req_addr = 10'h000;
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL wr_resp_one_cycle: got %b expected 0", a_resp_valid); end
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL rd_accept_k5: ready got %b expected 0", a_req_ready); end
        for (int n = 6; n <= 8; n++) begin
            tick;
            checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_resp k+%0d: got %b expected 0", n, a_resp_valid); end
        end
        tick;                                          // edge k+9
        checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL rd_resp_k9: got %b expected 1", a_resp_valid); end
        checks++; if (a_resp_rdata !== D1) begin failures++; $display("FAIL rd_data_040: got %h expected %h", a_resp_rdata, D1); end
    endtask

    task automatic test_top_block;
        int lat; logic [127:0] rd;
        xfer(1'b1, 10'h3F0, D2, lat, rd);
        checks++; if (lat != 4) begin failures++; $display("FAIL top_wr_latency: got %0d expected 4", lat); end
        xfer(1'b0, 10'h3FF, 128'h0, lat, rd);
        checks++; if (lat != 4) begin failures++; $display("FAIL top_rd_latency: got %0d expected 4", lat); end
        checks++; if (rd !== D2) begin failures++; $display("FAIL top_rd_data: got %h expected %h", rd, D2); end
        xfer(1'b0, 10'h00F, 128'h0, lat, rd);
        checks++; if (rd !== D0) begin failures++; $display("FAIL block0_unchanged: got %h expected %h", rd, D0); end
    endtask

    task automatic test_busy;
        int resp_cnt = 0;
        int t1 = -1, t2 = -1;
        logic [127:0] d1 = '0, d2 = '0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 10'h040;
        tick;                                          // edge k
        a_req_addr = 10'h3F0;
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready_k0: got %b expected 0", a_req_ready); end
        for (int n = 1; n <= 12; n++) begin
            tick;
            if (n <= 3) begin
                checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready k+%0d: got %b expected 0", n, a_req_ready); end
            end
            if (a_resp_valid) begin
                resp_cnt++;
                if (t1 < 0) begin t1 = n; d1 = a_resp_rdata; end
                else if (t2 < 0) begin t2 = n; d2 = a_resp_rdata; end
            end
            if (n == 5) begin
                a_req_valid = 1'b0;
                checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL busy_second_accept_k5: ready got %b expected 0", a_req_ready); end
            end
        end
        checks++; if (resp_cnt != 2) begin failures++; $display("FAIL busy_resp_count: got %0d expected 2", resp_cnt); end
        checks++; if (t1 != 4) begin failures++; $display("FAIL busy_first_resp_edge: got %0d expected 4", t1); end
        checks++; if (d1 !== D1) begin failures++; $display("FAIL busy_first_data: got %h expected %h", d1, D1); end
        checks++; if (t2 != 9) begin failures++; $display("FAIL busy_second_resp_edge: got %0d expected 9", t2); end
        checks++; if (d2 !== D2) begin failures++; $display("FAIL busy_second_data: got %h expected %h", d2, D2); end
    endtask

    task automatic test_reset_mid_write;
        int lat; logic [127:0] rd;
        int resp_cnt = 0;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 10'h080; a_req_wdata = DX;
        tick;                                          // edge k
        a_req_valid = 1'b0;
        tick;                                          // edge k+1
        #3 reset_n = 1'b0;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL async_reset_resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 128'h0) begin failures++; $display("FAIL async_reset_rdata: got %h expected 0", a_resp_rdata); end
        tick;                                          // edge k+2, in reset
        tick;
        reset_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick;
            if (a_resp_valid) resp_cnt++;
        end
        checks++; if (resp_cnt != 0) begin failures++; $display("FAIL aborted_write_resp: got %0d expected 0", resp_cnt); end
        xfer(1'b0, 10'h080, 128'h0, lat, rd);
        checks++; if (rd !== D8) begin failures++; $display("FAIL aborted_write_data: got %h expected %h", rd, D8); end
    endtask

    task automatic test_first_accept;
        int lat; logic [127:0] rd;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        xfer(1'b0, 10'h3F4, 128'h0, lat, rd);
        checks++; if (lat != 4) begin failures++; $display("FAIL first_accept_latency: got %0d expected 4", lat); end
        checks++; if (rd !== D2) begin failures++; $display("FAIL first_accept_data: got %h expected %h", rd, D2); end
    endtask

    task automatic test_latency1;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 10'h040; b_req_wdata = D1;
        tick;                                          // edge k
        b_req_valid = 1'b0; b_req_wdata = ~D1;
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL l1_wr_early: got %b expected 0", b_resp_valid); end
        checks++; if (b_req_ready !== 1'b0) begin failures++; $display("FAIL l1_wr_ready: got %b expected 0", b_req_ready); end
        tick;                                          // edge k+1
        checks++; if (b_resp_valid !== 1'b1) begin failures++; $display("FAIL l1_wr_resp_k1: got %b expected 1", b_resp_valid); end
        checks++; if (b_resp_rdata !== 128'h0) begin failures++; $display("FAIL l1_wr_rdata_unchanged: got %h expected 0", b_resp_rdata); end
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 10'h04C;
        tick;                                          // edge k+2
        b_req_valid = 1'b0;
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL l1_resp_one_cycle: got %b expected 0", b_resp_valid); end
        checks++; if (b_req_ready !== 1'b0) begin failures++; $display("FAIL l1_rd_accept_k2: ready got %b expected 0", b_req_ready); end
        tick;                                          // edge k+3
        checks++; if (b_resp_valid !== 1'b1) begin failures++; $display("FAIL l1_rd_resp_k3: got %b expected 1", b_resp_valid); end
        checks++; if (b_resp_rdata !== D1) begin failures++; $display("FAIL l1_rd_data: got %h expected %h", b_resp_rdata, D1); end
    endtask

    initial begin
        reset_n     = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        tick;
        tick;
        test_reset;
        reset_n = 1'b1;
        test_init;
        test_write_read;
        test_top_block;
        test_busy;
        test_reset_mid_write;
        test_first_accept;
        test_latency1;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
